// File: rtl/adc_scope_capture_pkg.sv
// adc_scope_capture_pkg: shared state encoding, mode codes and width helpers for the scope capture block
package adc_scope_capture_pkg;
  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_e;
  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_NORMAL = 2'd1;
  localparam logic [1:0] MODE_AUTO   = 2'd2;
  function automatic int addr_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/adc_scope_capture_if.sv
// adc_scope_capture_if: sample stream and frozen-window readout bus of the scope capture block
//   s_valid/s_data : one strobe per conversion set, channel 0 in the LSBs
//   rd_ch/rd_addr  : readout channel and window offset (0 = oldest sample)
//   rd_data        : readout sample, one cycle after rd_ch/rd_addr
//   master drives samples and read requests, slave is the capture block
interface adc_scope_capture_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 12,
  parameter int DEPTH  = 1024
);
  logic                                            s_valid;
  logic [NUM_CH*DATA_W-1:0]                        s_data;
  logic [adc_scope_capture_pkg::ch_w(NUM_CH)-1:0]  rd_ch;
  logic [adc_scope_capture_pkg::addr_w(DEPTH)-1:0] rd_addr;
  logic [DATA_W-1:0]                               rd_data;
  modport master (output s_valid, s_data, rd_ch, rd_addr, input rd_data);
  modport slave  (input s_valid, s_data, rd_ch, rd_addr, output rd_data);
endinterface

// File: rtl/adc_scope_capture_trig_detect.sv
// adc_scope_capture_trig_detect: level-crossing compare between the previous and current stored trigger-channel sample
//   clk/rst_n : clock, async active-low reset
//   clr_i     : forget the previous sample (acquisition restart)
//   en_i      : current sample is being stored
//   cur_i     : current trigger-channel sample
//   level_i   : unsigned threshold; slope_i 0 rising, 1 falling
//   hit_o     : crossing between stored previous sample and cur_i
module adc_scope_capture_trig_detect #(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] cur_i,
  input  logic [DATA_W-1:0] level_i,
  input  logic              slope_i,
  output logic              hit_o
);
  logic [DATA_W-1:0] prev_q;
  logic              prev_valid_q;
  assign hit_o = prev_valid_q && (slope_i ? (prev_q > level_i && cur_i <= level_i)
                                          : (prev_q < level_i && cur_i >= level_i));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else if (clr_i) begin
      prev_valid_q <= 1'b0;
    end else if (en_i) begin
      prev_q       <= cur_i;
      prev_valid_q <= 1'b1;
    end
endmodule

// File: rtl/adc_scope_capture.sv
// adc_scope_capture: multi-channel triggered circular capture buffer with frozen readout window
//   ref_clk/reset_n : clock, async active-low reset
//   arm             : (re)start acquisition from any state
//   release_i       : display end-of-frame; NORMAL/AUTO leave DONE
//   mode            : 0 SINGLE, 1 NORMAL, 2/3 AUTO
//   trig_ch/trig_level/trig_slope : trigger channel, threshold, 0 rising / 1 falling
//   decim           : only with SCOPE_DECIM_EN; stores every (decim+1)th s_valid
//   bus             : sample stream in, window readout (adc_scope_capture_if.slave)
//   busy/triggered/done : acquiring, last window ended by a real crossing, window frozen
module adc_scope_capture
  import adc_scope_capture_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 12,
  parameter int DEPTH   = 1024,
  parameter int PRETRIG = 256,
  parameter int AUTO_TO = 4096
) (
  input  logic                    ref_clk,
  input  logic                    reset_n,
  input  logic                    arm,
  input  logic                    release_i,
  input  logic [1:0]              mode,
  input  logic [ch_w(NUM_CH)-1:0] trig_ch,
  input  logic [DATA_W-1:0]       trig_level,
  input  logic                    trig_slope,
`ifdef SCOPE_DECIM_EN
  input  logic [7:0]              decim,
`endif
  adc_scope_capture_if.slave      bus,
  output logic                    busy,
  output logic                    triggered,
  output logic                    done
);
  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CH_W   = ch_w(NUM_CH);
  localparam int CNT_W  = $clog2(AUTO_TO > DEPTH ? AUTO_TO : DEPTH) + 1;
  localparam int W      = NUM_CH * DATA_W;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, start_ptr_q, start_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              triggered_q, triggered_d;
  logic              active, take, store, hit, at_to, forced;
  logic [W-1:0]      ram [DEPTH];
  logic [W-1:0]      rd_word_q;
  logic [CH_W-1:0]   rd_ch_q;
  assign active = state_q inside {PRE, ARMED, POST};
`ifdef SCOPE_DECIM_EN
  logic [7:0] dec_q;
  assign take = dec_q == 8'd0;
  always_ff @(posedge ref_clk or negedge reset_n)
    if (!reset_n) dec_q <= '0;
    else if (arm) dec_q <= '0;
    else if (bus.s_valid && active) dec_q <= dec_q == decim ? 8'd0 : dec_q + 8'd1;
`else
  assign take = 1'b1;
`endif
  // arm wins over a same-cycle sample so a restart never stores or triggers on it
  assign store  = bus.s_valid && active && take && !arm;
  // counter saturates at AUTO_TO so a long NORMAL wait cannot wrap into a false timeout
  assign at_to  = cnt_q == CNT_W'(AUTO_TO);
  assign forced = mode[1] && at_to;
  adc_scope_capture_trig_detect #(.DATA_W(DATA_W)) u_trig (
    .clk     (ref_clk),
    .rst_n   (reset_n),
    .clr_i   (arm),
    .en_i    (store),
    .cur_i   (bus.s_data[trig_ch*DATA_W +: DATA_W]),
    .level_i (trig_level),
    .slope_i (trig_slope),
    .hit_o   (hit)
  );
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    start_ptr_d = start_ptr_q;
    triggered_d = triggered_q;
    if (arm) begin
      state_d     = PRE;
      cnt_d       = '0;
      triggered_d = 1'b0;
    end else if (state_q == DONE && release_i && mode != MODE_SINGLE) begin
      state_d = PRE;
      cnt_d   = '0;
    end else if (store) begin
      cnt_d = cnt_q + 1'b1;
      case (state_q)
        PRE: if (cnt_q == CNT_W'(PRETRIG - 1)) begin
          state_d = ARMED;
          cnt_d   = '0;
        end
        ARMED: if (hit || forced) begin
          state_d     = POST;
          cnt_d       = '0;
          start_ptr_d = wr_ptr_q - ADDR_W'(PRETRIG);
          triggered_d = hit;
        end else begin
          cnt_d = at_to ? cnt_q : cnt_q + 1'b1;
        end
        POST: if (cnt_q == CNT_W'(DEPTH - PRETRIG - 2)) state_d = DONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end
  always_ff @(posedge ref_clk or negedge reset_n)
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      start_ptr_q <= '0;
      triggered_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      start_ptr_q <= start_ptr_d;
      triggered_q <= triggered_d;
      if (store) wr_ptr_q <= wr_ptr_q + 1'b1;
    end
  always_ff @(posedge ref_clk)
    if (store) ram[wr_ptr_q] <= bus.s_data;
  always_ff @(posedge ref_clk or negedge reset_n)
    if (!reset_n) begin
      rd_word_q <= '0;
      rd_ch_q   <= '0;
    end else begin
      rd_word_q <= ram[start_ptr_q + bus.rd_addr];
      rd_ch_q   <= bus.rd_ch;
    end
  assign bus.rd_data = rd_word_q[rd_ch_q*DATA_W +: DATA_W];
  assign busy        = active;
  assign done        = state_q == DONE;
  assign triggered   = triggered_q;
endmodule

// File: tb/tb_adc_scope_capture.sv
// tb_adc_scope_capture: randomized and directed checks of adc_scope_capture against a sample-list reference model
module tb_adc_scope_capture;
  localparam int NUM_CH = 4, DATA_W = 12, DEPTH = 16, PRETRIG = 4, AUTO_TO = 8;
  localparam int W = NUM_CH * DATA_W;
  logic              ref_clk = 1'b0, reset_n = 1'b0, arm = 1'b0, release_i = 1'b0, trig_slope = 1'b0;
  logic [1:0]        mode = '0, trig_ch = '0;
  logic [DATA_W-1:0] trig_level = '0;
  logic [7:0]        decim = '0;
  logic              busy, triggered, done;
  int                errors = 0, checks = 0, sv_cnt = 0;
  logic [W-1:0]      acq[$], stim[$];
  adc_scope_capture_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
  adc_scope_capture #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .PRETRIG(PRETRIG), .AUTO_TO(AUTO_TO)) dut (
    .ref_clk    (ref_clk),
    .reset_n    (reset_n),
    .arm        (arm),
    .release_i  (release_i),
    .mode       (mode),
    .trig_ch    (trig_ch),
    .trig_level (trig_level),
    .trig_slope (trig_slope),
`ifdef SCOPE_DECIM_EN
    .decim      (decim),
`endif
    .bus        (bus.slave),
    .busy       (busy),
    .triggered  (triggered),
    .done       (done)
  );
  always #5 ref_clk = ~ref_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge ref_clk);
    #1;
  endtask
  function automatic int chv(input logic [W-1:0] w, input int ch);
    return int'(w[ch*DATA_W +: DATA_W]);
  endfunction
  function automatic logic [W-1:0] mk(input int ch, input int val);
    logic [W-1:0] w;
    for (int c = 0; c < NUM_CH; c++) w[c*DATA_W +: DATA_W] = DATA_W'($urandom);
    w[ch*DATA_W +: DATA_W] = DATA_W'(val);
    return w;
  endfunction
  // index of the first stored sample that ends ARMED (crossing or AUTO timeout), -1 if none yet
  function automatic int find_trig(output bit real_x);
    int p, c, l;
    real_x = 1'b0;
    for (int i = PRETRIG; i < acq.size(); i++) begin
      p = chv(acq[i-1], int'(trig_ch));
      c = chv(acq[i], int'(trig_ch));
      l = int'(trig_level);
      real_x = trig_slope ? (p > l && c <= l) : (p < l && c >= l);
      if (real_x || (mode[1] && i == PRETRIG + AUTO_TO)) return i;
    end
    real_x = 1'b0;
    return -1;
  endfunction
  function automatic bit m_done();
    bit x;
    int t;
    t = find_trig(x);
    return t >= 0 && acq.size() >= t + DEPTH - PRETRIG;
  endfunction
  task automatic cfg(input int m, input int ch, input int lvl, input int sl);
    mode = 2'(m);
    trig_ch = 2'(ch);
    trig_level = DATA_W'(lvl);
    trig_slope = 1'(sl);
  endtask
  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
    acq.delete();
    sv_cnt = 0;
  endtask
  task automatic do_release();
    bit clr;
    clr = m_done() && mode != 2'd0;
    release_i = 1'b1;
    step();
    release_i = 1'b0;
    if (clr) acq.delete();
  endtask
  task automatic drive(input logic [W-1:0] w);
    bit keep;
    keep = !m_done() && (sv_cnt % (int'(decim) + 1) == 0);
    if (!m_done()) sv_cnt++;
    bus.s_valid = 1'b1;
    bus.s_data = w;
    step();
    bus.s_valid = 1'b0;
    if (keep) acq.push_back(w);
  endtask
  task automatic run_stim(input string tag);
    foreach (stim[k]) begin
      drive(stim[k]);
      check({tag, " done"}, done, m_done());
      check({tag, " busy"}, busy, !m_done());
    end
    stim.delete();
  endtask
  task automatic rd(input int ch, input int a, output int v);
    bus.rd_ch = 2'(ch);
    bus.rd_addr = 4'(a);
    step();
    v = int'(bus.rd_data);
  endtask
  task automatic check_window(input string tag);
    bit x;
    int t, v;
    t = find_trig(x);
    check({tag, " triggered"}, triggered, x);
    for (int a = 0; a < DEPTH; a++)
      for (int ch = 0; ch < NUM_CH; ch++) begin
        rd(ch, a, v);
        check({tag, " rd"}, v, chv(acq[t - PRETRIG + a], ch));
      end
  endtask
  initial begin
    int v;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.rd_ch = '0;
    bus.rd_addr = '0;
    repeat (2) step();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset triggered", triggered, 0);
    check("reset rd_data", bus.rd_data, 0);
    reset_n = 1'b1;
    step();
    // single rising ramp; trailing samples must not disturb the frozen window
    cfg(0, 1, 10, 0);
    do_arm();
    for (int k = 0; k < 30; k++) stim.push_back(mk(1, k));
    run_stim("single");
    check_window("single");
    rd(1, 0, v);        check("single addr0", v, 6);
    rd(1, PRETRIG, v);  check("single trig sample", v, 10);
    rd(1, 15, v);       check("single addr15", v, 21);
    do_release();
    check("single holds on release", done, 1);
    // normal mode, then release into a falling acquisition across the pointer wrap
    cfg(1, 1, 10, 0);
    do_arm();
    for (int k = 0; k < 26; k++) stim.push_back(mk(1, k));
    run_stim("normal1");
    check_window("normal1");
    trig_level = 12'd30;
    trig_slope = 1'b1;
    do_release();
    check("normal release busy", busy, 1);
    check("normal release done", done, 0);
    for (int k = 40; k > 5; k--) stim.push_back(mk(1, k));
    run_stim("normal2");
    check_window("normal2");
    rd(1, 0, v);  check("normal2 addr0", v, 34);
    rd(1, 15, v); check("normal2 addr15", v, 19);
    // auto timeout with a release pulse that must be ignored while armed
    cfg(2, 1, 500, 0);
    do_arm();
    for (int k = 0; k < 6; k++) stim.push_back(mk(1, 100));
    run_stim("auto");
    do_release();
    check("auto release ignored", busy, 1);
    for (int k = 0; k < 17; k++) stim.push_back(mk(1, 100));
    run_stim("auto");
    check("auto not done at 23", done, 0);
    stim.push_back(mk(1, 100));
    run_stim("auto");
    check("auto done at 24", done, 1);
    check_window("auto");
    // arm colliding with a crossing: no trigger may be latched
    cfg(1, 1, 10, 0);
    do_arm();
    for (int k = 0; k < 9; k++) stim.push_back(mk(1, k));
    run_stim("armhit");
    bus.s_valid = 1'b1;
    bus.s_data = mk(1, 10);
    arm = 1'b1;
    step();
    arm = 1'b0;
    bus.s_valid = 1'b0;
    acq.delete();
    sv_cnt = 0;
    check("armhit busy", busy, 1);
    check("armhit done", done, 0);
    check("armhit triggered", triggered, 0);
    for (int k = 0; k < 15; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data = mk(1, 0);
      step();
    end
    bus.s_valid = 1'b0;
    check("armhit no window", done, 0);
    // asynchronous reset in POST
    cfg(0, 1, 10, 0);
    do_arm();
    bus.rd_ch = 2'd1;
    bus.rd_addr = 4'd4;
    for (int k = 0; k < 15; k++) stim.push_back(mk(1, k));
    run_stim("post");
    check("post triggered", triggered, 1);
    check("post rd_data", bus.rd_data, 10);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid reset busy", busy, 0);
    check("mid reset done", done, 0);
    check("mid reset triggered", triggered, 0);
    check("mid reset rd_data", bus.rd_data, 0);
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data = mk(1, 20 + k);
      step();
    end
    bus.s_valid = 1'b0;
    check("idle after reset busy", busy, 0);
    check("idle after reset done", done, 0);
`ifdef SCOPE_DECIM_EN
    decim = 8'd2;
    cfg(0, 1, 20, 0);
    do_arm();
    for (int k = 0; k < 80; k++) stim.push_back(mk(1, k));
    run_stim("decim");
    check_window("decim");
    rd(1, PRETRIG, v); check("decim trig sample", v, 21);
    rd(1, 0, v);       check("decim addr0", v, 9);
    decim = 8'd0;
`endif
    // randomized random-walk trials across all modes, slopes and channels
    for (int n = 0; n < 16; n++) begin
      int lvl, d;
      lvl = int'($urandom_range(200, 3800));
      cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), lvl, int'($urandom_range(0, 1)));
      do_arm();
      d = int'($urandom_range(0, 60));
      v = lvl + d - 30;
      for (int k = 0; k < 40; k++) begin
        d = int'($urandom_range(0, 12));
        v += d - 6;
        stim.push_back(mk(int'(trig_ch), v));
      end
      run_stim("rand");
      if (m_done()) check_window("rand");
      if (mode != 2'd0 && m_done()) begin
        do_release();
        for (int k = 0; k < 30; k++) begin
          d = int'($urandom_range(0, 12));
          v += d - 6;
          stim.push_back(mk(int'(trig_ch), v));
        end
        run_stim("rand2");
        if (m_done()) check_window("rand2");
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
